com_testx_sequencer: RTL and testbench
======================================

# com_testx_sequencer

Sequencer for the test-enable decoder: it generates the decoder's `op_code_w_reset`, `op_code_w_execute` and one-hot `test_number` controls so that a selected subset of the four test engines runs back-to-back, for a programmed number of passes, without software handshaking each test. It sits between the AXI-lite register bank and the decoder, and consumes per-engine completion pulses.

## Interface
- `GAP_CYCLES`, 4, idle cycles between consecutive tests with execute low (legal range ≥1).
- `TIMEOUT_W`, 16, width of the per-test watchdog limit.
- `clk` in 1: single clock; all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `seq_start` in 1: start pulse; honoured only in IDLE.
- `seq_abort` in 1: abort request; honoured in any non-IDLE state.
- `test_mask` in 4: bit i enables test i+1; sampled when start is accepted.
- `loop_count` in 8: passes over the mask; 0 = run until abort; sampled at start.
- `timeout_cycles` in TIMEOUT_W: per-test watchdog limit; 0 disables; sampled at start.
- `test_done` in 4: bit i is a one-cycle completion pulse from engine i+1.
- `op_code_w_reset` out 1: decoder reset control.
- `op_code_w_execute` out 1: decoder execute control.
- `test_number` out 4: one-hot test select (4'h1/2/4/8), 0 when idle.
- `seq_busy` out 1: high in every state except IDLE.
- `seq_done` out 1: one-cycle pulse at sequence end (normal, abort or timeout).
- `seq_error` out 1: sticky; set on abort or timeout, cleared on next accepted start.
- `pass_count` out 8: completed passes; wraps mod 256 when loop_count = 0.
- `tests_run` out 8: completed tests in this sequence, saturates at 255.

## Operation
- All outputs registered; reset value 0 for every output; state IDLE.
- States: IDLE, CLR, RUN, GAP, ABORT, DONE.
- IDLE:
  - `seq_start` with `seq_abort` low and mask ≠ 0: latch mask, loop and timeout; clear `pass_count`, `tests_run`, `seq_error`; set idx to the lowest set mask bit; go to CLR.
  - `seq_start` with mask = 0: no test runs; go to DONE.
  - `seq_start` with `seq_abort` high in the same cycle: start is ignored.
- CLR (1 cycle): `op_code_w_reset`=1, `test_number`=onehot(idx), execute=0; go to RUN.
- RUN: execute=1, `test_number` held, watchdog counts from 0.
  - `test_done[idx]`: increment `tests_run`; go to GAP.
  - Other `test_done` bits are ignored.
- GAP: execute=0, `test_number` held, lasts GAP_CYCLES cycles, then:
  - If a higher mask bit is set, idx becomes the next set bit; go to CLR.
  - Otherwise increment `pass_count`. If loop ≠ 0 and the new `pass_count` equals loop, go to DONE. Otherwise wrap idx to the lowest set bit and go to CLR.
- ABORT (1 cycle): `op_code_w_reset`=1, execute=0, `seq_error`=1; go to DONE.
- DONE (1 cycle): `seq_done`=1, execute=0, `test_number`=0; go to IDLE.
- Priority in one cycle: `seq_abort` > watchdog expiry > `test_done`.
- Async reset mid-sequence: everything returns to reset values immediately. The decoder is released with execute=0.

## Timing
- Start accepted at edge N: CLR in cycle N+1, execute high from N+2, decoder enable high from N+3.
- `test_done` in cycle M: execute low in M+1. Next CLR in M+1+GAP_CYCLES.
- Final test done in cycle M: `seq_done` in M+1+GAP_CYCLES, `seq_busy` low the next cycle.
- Abort sampled in cycle A: ABORT in A+1, `seq_done` in A+2, `seq_busy` low in A+3.
- Mask = 0 start at edge N: `seq_done` in N+1; `tests_run`=0, `pass_count`=0.

## Configuration
- `COM_TESTX_SEQ_TIMEOUT_EN` defined:
  - Watchdog compiled in. If RUN lasts `timeout_cycles` cycles (nonzero) without `test_done[idx]`, go to ABORT.
  - `tests_run` is not incremented.
- Not defined:
  - Watchdog logic is absent and `timeout_cycles` is ignored.
  - RUN waits indefinitely; only `seq_abort` or reset leaves it.

## Test plan
- Mask 4'b0101, loop 1, each done 10 cycles after execute rises → `test_number` sequence 1 then 4, each preceded by a 1-cycle `op_code_w_reset`. `tests_run`=2, `pass_count`=1, one `seq_done`, `seq_error`=0.
- Mask 4'b1111, loop 3 → 12 CLR/RUN pairs in order 1,2,4,8 repeated; `pass_count`=3; execute low for exactly GAP_CYCLES between tests.
- Mask 4'b0010, loop 0, abort after 5 passes → ABORT cycle with reset high, `seq_done` pulse, `seq_error`=1, `pass_count`=5.
- With the macro, timeout 20 and no `test_done` → ABORT entered 20 cycles into RUN, `seq_error`=1, `tests_run`=0. Without the macro → still in RUN after 1000 cycles.
- Start with mask 0 → `seq_done` next cycle, no execute. Start + abort in the same cycle → stays IDLE. Non-selected `test_done` bits are ignored.
- `reset_n` low during RUN → all outputs 0 asynchronously; a new start afterwards behaves as from power-up.

Source files
------------

// File: rtl/com_testx_sequencer.sv
// Test-enable sequencer: walks the selected test engines through CLR/RUN/GAP for a number of passes.
// Optional per-test watchdog is compiled in with COM_TESTX_SEQ_TIMEOUT_EN.
module com_testx_sequencer #(
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 seq_start,
    input  logic                 seq_abort,
    input  logic [3:0]           test_mask,
    input  logic [7:0]           loop_count,
    input  logic [TIMEOUT_W-1:0] timeout_cycles,
    input  logic [3:0]           test_done,
    output logic                 op_code_w_reset,
    output logic                 op_code_w_execute,
    output logic [3:0]           test_number,
    output logic                 seq_busy,
    output logic                 seq_done,
    output logic                 seq_error,
    output logic [7:0]           pass_count,
    output logic [7:0]           tests_run
);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, CLR, RUN, GAP, ABORT, DONE} state_t;

    state_t        state, state_nxt;
    logic [3:0]    mask_q;
    logic [7:0]    loop_q;
    logic [1:0]    idx, idx_nxt;
    logic [GW-1:0] gap_cnt, gap_cnt_nxt;
    logic [7:0]    pass_nxt, tests_nxt;
    logic          err_nxt;
    logic [3:0]    above;
    logic          timeout_hit;
    logic          start_ok;

    function automatic logic [1:0] lowest(input logic [3:0] m);
        lowest = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (m[i]) lowest = 2'(i);
    endfunction

    assign start_ok = (state == IDLE) && seq_start && !seq_abort;
    assign above    = mask_q & (4'b1110 << idx);

`ifdef COM_TESTX_SEQ_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_q, wd_cnt;

    // wd_cnt reads 0 in the first RUN cycle, so expiry lands exactly tmo_q cycles into RUN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q  <= '0;
            wd_cnt <= '0;
        end else begin
            if (start_ok) tmo_q <= timeout_cycles;
            wd_cnt <= (state == RUN) ? wd_cnt + 1'b1 : '0;
        end
    end

    assign timeout_hit = (state == RUN) && (tmo_q != '0) && (wd_cnt == tmo_q - 1'b1);
`else
    logic unused_timeout;
    assign unused_timeout = ^timeout_cycles;
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            mask_q  <= '0;
            loop_q  <= '0;
            idx     <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            gap_cnt <= gap_cnt_nxt;
            if (start_ok) begin
                mask_q <= test_mask;
                loop_q <= loop_count;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        gap_cnt_nxt = gap_cnt;
        pass_nxt    = pass_count;
        tests_nxt   = tests_run;
        err_nxt     = seq_error;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    pass_nxt  = '0;
                    tests_nxt = '0;
                    err_nxt   = 1'b0;
                    if (test_mask != 4'h0) begin
                        idx_nxt   = lowest(test_mask);
                        state_nxt = CLR;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            CLR: state_nxt = seq_abort ? ABORT : RUN;
            RUN: begin
                if (seq_abort || timeout_hit) begin
                    state_nxt = ABORT;
                end else if (test_done[idx]) begin
                    tests_nxt   = (tests_run == 8'hFF) ? tests_run : tests_run + 8'd1;
                    gap_cnt_nxt = '0;
                    state_nxt   = GAP;
                end
            end
            GAP: begin
                if (seq_abort) begin
                    state_nxt = ABORT;
                end else if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                    if (|above) begin
                        idx_nxt   = lowest(above);
                        state_nxt = CLR;
                    end else begin
                        pass_nxt = pass_count + 8'd1;
                        if (loop_q != 8'd0 && pass_nxt == loop_q) begin
                            state_nxt = DONE;
                        end else begin
                            idx_nxt   = lowest(mask_q);
                            state_nxt = CLR;
                        end
                    end
                end else begin
                    gap_cnt_nxt = gap_cnt + 1'b1;
                end
            end
            // ABORT and DONE already end the sequence, so a late abort has nothing left to do
            ABORT:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (state_nxt == ABORT) err_nxt = 1'b1;
    end

    // Outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_code_w_reset   <= 1'b0;
            op_code_w_execute <= 1'b0;
            test_number       <= 4'h0;
            seq_busy          <= 1'b0;
            seq_done          <= 1'b0;
            seq_error         <= 1'b0;
            pass_count        <= 8'd0;
            tests_run         <= 8'd0;
        end else begin
            op_code_w_reset   <= (state_nxt == CLR) || (state_nxt == ABORT);
            op_code_w_execute <= (state_nxt == RUN);
            test_number       <= (state_nxt == CLR || state_nxt == RUN || state_nxt == GAP)
                                 ? (4'b0001 << idx_nxt) : 4'h0;
            seq_busy          <= (state_nxt != IDLE);
            seq_done          <= (state_nxt == DONE);
            seq_error         <= err_nxt;
            pass_count        <= pass_nxt;
            tests_run         <= tests_nxt;
        end
    end
endmodule

// File: tb/tb_com_testx_sequencer.sv
// Scoreboard bench for com_testx_sequencer: directed sequences, expected test order and end-of-sequence results.
module tb_com_testx_sequencer;
    localparam int GAP_CYCLES = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        seq_start = 1'b0;
    logic        seq_abort = 1'b0;
    logic [3:0]  test_mask = 4'h0;
    logic [7:0]  loop_count = 8'd0;
    logic [15:0] timeout_cycles = 16'd0;
    logic [3:0]  test_done = 4'h0;
    logic        op_code_w_reset, op_code_w_execute, seq_busy, seq_done, seq_error;
    logic [3:0]  test_number;
    logic [7:0]  pass_count, tests_run;

    com_testx_sequencer #(.GAP_CYCLES(GAP_CYCLES), .TIMEOUT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .seq_start(seq_start), .seq_abort(seq_abort),
        .test_mask(test_mask), .loop_count(loop_count), .timeout_cycles(timeout_cycles),
        .test_done(test_done), .op_code_w_reset(op_code_w_reset),
        .op_code_w_execute(op_code_w_execute), .test_number(test_number),
        .seq_busy(seq_busy), .seq_done(seq_done), .seq_error(seq_error),
        .pass_count(pass_count), .tests_run(tests_run)
    );

    always #5 clk = ~clk;

    typedef struct {logic [7:0] pass; logic [7:0] tests; logic err;} exp_t;
    exp_t       sb_q[$];
    logic [3:0] tn_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: end-of-sequence results and CLR->RUN test order
    exp_t       e;
    logic       exec_q = 1'b0, rst_q = 1'b0;
    logic [3:0] tn_prev = 4'h0;
    int         gap_len = 0;
    always @(negedge clk) begin
        if (seq_done) begin
            if (sb_q.size() == 0) check("unexpected_done", 1, 0);
            else begin
                e = sb_q.pop_front();
                check("pass_count", pass_count, e.pass);
                check("tests_run", tests_run, e.tests);
                check("seq_error", seq_error, e.err);
            end
        end
        if (op_code_w_execute && !exec_q) begin
            if (tn_q.size() == 0) check("unexpected_test", 1, 0);
            else check("test_number", test_number, tn_q.pop_front());
            check("clr_before_run", {rst_q, tn_prev}, {1'b1, test_number});
            if (gap_len > 0) check("gap_len", gap_len, GAP_CYCLES);
            gap_len = 0;
        end
        if (seq_busy && !op_code_w_execute && !op_code_w_reset && test_number != 4'h0) gap_len++;
        if (!seq_busy) gap_len = 0;
        exec_q  = op_code_w_execute;
        rst_q   = op_code_w_reset;
        tn_prev = test_number;
    end

    // Engine model: completes the running test 10 cycles after execute rises; optional stray pulses
    logic resp_en = 1'b0, noise_en = 1'b0, rexec_q = 1'b0;
    int   rcnt = 0;
    always @(negedge clk) begin
        test_done = 4'h0;
        if (op_code_w_execute && !rexec_q) rcnt = 0;
        else if (op_code_w_execute) rcnt++;
        if (resp_en && op_code_w_execute) begin
            if (rcnt == 9) test_done = test_number;
            else if (noise_en && rcnt == 3) test_done = ~test_number;
        end
        rexec_q = op_code_w_execute;
    end

    task automatic start_seq(input logic [3:0] m, input logic [7:0] l, input logic [15:0] t);
        test_mask = m; loop_count = l; timeout_cycles = t;
        seq_start = 1'b1;
        @(negedge clk);
        seq_start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !seq_busy) begin ok = 1; break; end
        end
        if (!ok) check({"idle_timeout_", name}, 0, 1);
    endtask

    task automatic wait_exec(input string name, input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (op_code_w_execute) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) check({"exec_timeout_", name}, 0, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_state", {op_code_w_reset, op_code_w_execute, test_number, seq_busy,
                              seq_done, seq_error, pass_count, tests_run}, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Mask 0101, one pass, with stray done pulses from the idle engines
        resp_en = 1; noise_en = 1;
        tn_q.push_back(4'h1); tn_q.push_back(4'h4);
        sb_q.push_back('{8'd1, 8'd2, 1'b0});
        start_seq(4'b0101, 8'd1, 16'd0);
        check("clr_first_cycle", {op_code_w_reset, op_code_w_execute, test_number}, {1'b1, 1'b0, 4'h1});
        wait_idle("mask0101", 300);
        noise_en = 0;

        // All four engines, three passes
        for (int p = 0; p < 3; p++) begin
            tn_q.push_back(4'h1); tn_q.push_back(4'h2); tn_q.push_back(4'h4); tn_q.push_back(4'h8);
        end
        sb_q.push_back('{8'd3, 8'd12, 1'b0});
        start_seq(4'b1111, 8'd3, 16'd0);
        wait_idle("mask1111", 1000);

        // Endless loop on engine 2, aborted once five passes complete
        for (int p = 0; p < 5; p++) tn_q.push_back(4'h2);
        sb_q.push_back('{8'd5, 8'd5, 1'b1});
        start_seq(4'b0010, 8'd0, 16'd0);
        begin
            bit ok = 0;
            for (int i = 0; i < 500; i++) begin
                if (pass_count == 8'd5) begin ok = 1; break; end
                @(negedge clk);
            end
            if (!ok) check("pass5_timeout", 0, 1);
        end
        seq_abort = 1'b1;
        @(negedge clk);
        seq_abort = 1'b0;
        check("abort_cycle", {op_code_w_reset, op_code_w_execute, seq_error, seq_busy}, 4'b1011);
        @(negedge clk);
        check("abort_done", {seq_done, seq_busy}, 2'b11);
        @(negedge clk);
        check("abort_idle", seq_busy, 0);
        wait_idle("abort", 20);

        // No engine ever completes
        resp_en = 0;
        tn_q.push_back(4'h1);
        sb_q.push_back('{8'd0, 8'd0, 1'b1});
        start_seq(4'b0001, 8'd1, 16'd20);
        wait_exec("watchdog", 10);
`ifdef COM_TESTX_SEQ_TIMEOUT_EN
        begin
            int cnt = 0;
            while (!op_code_w_reset && cnt < 100) begin @(negedge clk); cnt++; end
            check("timeout_len", cnt, 20);
            check("timeout_abort", {op_code_w_execute, seq_error, tests_run}, {1'b0, 1'b1, 8'd0});
        end
`else
        repeat (1000) @(negedge clk);
        check("still_running", {seq_busy, op_code_w_execute, test_number}, {1'b1, 1'b1, 4'h1});
        seq_abort = 1'b1;
        @(negedge clk);
        seq_abort = 1'b0;
`endif
        wait_idle("watchdog", 50);

        // Empty mask: immediate done, no execute
        sb_q.push_back('{8'd0, 8'd0, 1'b0});
        start_seq(4'b0000, 8'd5, 16'd0);
        check("mask0_done", {seq_done, op_code_w_execute, test_number}, {1'b1, 1'b0, 4'h0});
        wait_idle("mask0", 10);

        // Start and abort together: ignored
        test_mask = 4'b0001; seq_start = 1'b1; seq_abort = 1'b1;
        @(negedge clk);
        seq_start = 1'b0; seq_abort = 1'b0;
        check("start_abort_ignored", {seq_busy, seq_done, op_code_w_reset}, 0);
        repeat (3) @(negedge clk);
        check("start_abort_idle", seq_busy, 0);

        // Asynchronous reset while running, then a fresh sequence
        tn_q.push_back(4'h4);
        start_seq(4'b0100, 8'd1, 16'd0);
        wait_exec("reset_run", 10);
        #2 reset_n = 1'b0;
        #1 check("async_reset", {op_code_w_reset, op_code_w_execute, test_number, seq_busy,
                                 seq_done, seq_error, pass_count, tests_run}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        resp_en = 1;
        tn_q.push_back(4'h1); tn_q.push_back(4'h4);
        sb_q.push_back('{8'd1, 8'd2, 1'b0});
        start_seq(4'b0101, 8'd1, 16'd0);
        wait_idle("after_reset", 300);

        check("tn_q_empty", tn_q.size(), 0);
        check("sb_q_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
